pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Programmable pulse-train transmitter: on a start request it emits a configured number of rectangular pulses with programmable high and low widths (in clock cycles), then signals completion. It is the stimulus-side counterpart of the team's rising-edge pulse counter and drives that counter's `pulse` input in loopback tests and on the board. Pulse output and all status outputs are registered.

## Interface
- `CNT_W`, default 16: width of pulse-count fields.
- `LEN_W`, default 16: width of high/low phase-length fields.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: single-cycle request; sampled only in IDLE.
- `abort`  in  1: terminates an active train.
- `pulse_num`  in  CNT_W: number of pulses to send; latched at start.
- `high_len`  in  LEN_W: high-phase length in cycles; latched at start.
- `low_len`  in  LEN_W: low-phase length in cycles; latched at start.
- `pulse`  out  1: generated pulse train (registered).
- `busy`  out  1: high while a train is in progress.
- `done`  out  1: one-cycle strobe on normal completion.
- `sent_count`  out  CNT_W: number of completed high phases in the current or last train.

## Operation
- States: IDLE, HIGH, LOW.
- Reset (async, any time, including mid-train): state IDLE; `pulse`=0, `busy`=0, `done`=0, `sent_count`=0; internal latches and counters cleared.
- IDLE: `start`=1 and `abort`=0 latches `pulse_num`, `high_len`, `low_len` and clears `sent_count`.
  - If latched `pulse_num`=0: remain IDLE, assert `done` for one cycle, `busy` stays 0, no pulse.
  - Otherwise go to HIGH: `pulse`←1, `busy`←1, phase counter loaded.
- Length clamp: latched `high_len`=0 or `low_len`=0 is treated as 1. A phase never lasts zero cycles.
- HIGH: `pulse` held at 1 for exactly H = max(high_len,1) cycles. On leaving HIGH, `sent_count` increments by 1 and the state goes to LOW.
- LOW: `pulse` held at 0 for exactly L = max(low_len,1) cycles. The trailing low phase after the last pulse is always emitted.
  - If `sent_count` < latched `pulse_num`: go to HIGH.
  - Otherwise go to IDLE with `busy`←0 and `done`←1 for one cycle.
- `start` while busy: ignored. Inputs changing mid-train have no effect, because the values are latched.
- `abort`=1 in HIGH or LOW: next edge gives IDLE, `pulse`=0, `busy`=0, and no `done`.
  - `sent_count` keeps its value. A truncated high phase is not counted.
  - `abort` in IDLE is a no-op and suppresses a coincident `start`.
- `sent_count` cannot wrap, because it is bounded by `pulse_num` ≤ 2^CNT_W−1.
- Phase counters are LEN_W wide and count down to 1, so they do not wrap.

## Timing
- `start` sampled at edge E0 → `pulse`=1 and `busy`=1 visible after E0, i.e. from cycle 1.
- Pulse k (k=1..N) is high during cycles (k−1)(H+L)+1 … (k−1)(H+L)+H.
- `busy` is high for exactly N·(H+L) cycles.
- `done` is high in cycle N·(H+L)+1, coincident with `busy`=0.
- A new `start` is accepted in the same cycle `done` is high. The next train's first pulse then follows with no gap beyond the trailing low phase.
- `sent_count` updates in the same cycle `pulse` falls.
- `abort` sampled at edge EA → `pulse`=0 and `busy`=0 from the cycle after EA.
- Downstream receiver compatibility: with H≥1 and L≥1, every pulse is a clean 0→1→0 transition seen by a two-flop edge detector. The receiver counts exactly N rising edges.

## Test plan
- Basic train: `pulse_num`=3, `high_len`=2, `low_len`=3, `start` pulse → `pulse` pattern 11000 repeated 3×. `busy` high for 15 cycles, `done` in cycle 16, `sent_count`=3.
- Zero/clamp cases:
  - `pulse_num`=0 → `done` one cycle after start, `busy` never 1, `pulse` stays 0.
  - `pulse_num`=2, `high_len`=0, `low_len`=0 → pattern 1010, `busy` 4 cycles.
- Abort mid-high: N=5, H=4, L=4, `abort` in 2nd cycle of the 3rd high phase → `pulse` 0 next cycle, `busy` 0, no `done`, `sent_count`=2.
- Back-to-back and ignored start:
  - `start` during a train → no effect.
  - `start` in the `done` cycle with N=1, H=1, L=1 → second pulse begins the next cycle; `sent_count` reset to 0 then 1.
- Async reset mid-LOW: assert `rst` between edges → all outputs 0 immediately. After release, `start` with N=2, H=1, L=2 runs normally.
- Loopback: connect `pulse` to the team's pulse counter with `en_count`=1; N=100, H=1, L=1 → counter reads 100 when `done` is asserted plus 2 cycles.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse-train transmitter.
// On start it sends pulse_num pulses, each high for max(high_len,1) cycles
// and low for max(low_len,1) cycles, then strobes done. All outputs are registered.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_num,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_num,   w_num_n;
    logic [LEN_W-1:0] r_hlen,  w_hlen_n;
    logic [LEN_W-1:0] r_llen,  w_llen_n;
    logic [LEN_W-1:0] r_phase, w_phase_n;
    logic [CNT_W-1:0] r_sent,  w_sent_n;
    logic             r_pulse, w_pulse_n;
    logic             r_busy,  w_busy_n;
    logic             r_done,  w_done_n;

    // Zero lengths are clamped to one so a phase never vanishes.
    logic [LEN_W-1:0] w_hlen_clamp;
    logic [LEN_W-1:0] w_llen_clamp;

    assign w_hlen_clamp = (high_len == '0) ? LEN_W'(1) : high_len;
    assign w_llen_clamp = (low_len  == '0) ? LEN_W'(1) : low_len;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_hlen  <= '0;
            r_llen  <= '0;
            r_phase <= '0;
            r_sent  <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_num   <= w_num_n;
            r_hlen  <= w_hlen_n;
            r_llen  <= w_llen_n;
            r_phase <= w_phase_n;
            r_sent  <= w_sent_n;
            r_pulse <= w_pulse_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    // Next-state and next-output logic; the phase counter counts down to 1.
    always_comb begin
        w_state_n = r_state;
        w_num_n   = r_num;
        w_hlen_n  = r_hlen;
        w_llen_n  = r_llen;
        w_phase_n = r_phase;
        w_sent_n  = r_sent;
        w_pulse_n = r_pulse;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_num_n  = pulse_num;
                    w_hlen_n = w_hlen_clamp;
                    w_llen_n = w_llen_clamp;
                    w_sent_n = '0;
                    if (pulse_num == '0) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_state_n = HIGH;
                        w_pulse_n = 1'b1;
                        w_busy_n  = 1'b1;
                        w_phase_n = w_hlen_clamp;
                    end
                end
            end

            HIGH: begin
                if (abort) begin
                    w_state_n = IDLE;
                    w_pulse_n = 1'b0;
                    w_busy_n  = 1'b0;
                end else if (r_phase <= LEN_W'(1)) begin
                    w_state_n = LOW;
                    w_pulse_n = 1'b0;
                    w_sent_n  = r_sent + CNT_W'(1);
                    w_phase_n = r_llen;
                end else begin
                    w_phase_n = r_phase - LEN_W'(1);
                end
            end

            LOW: begin
                if (abort) begin
                    w_state_n = IDLE;
                    w_pulse_n = 1'b0;
                    w_busy_n  = 1'b0;
                end else if (r_phase <= LEN_W'(1)) begin
                    if (r_sent < r_num) begin
                        w_state_n = HIGH;
                        w_pulse_n = 1'b1;
                        w_phase_n = r_hlen;
                    end else begin
                        w_state_n = IDLE;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                    end
                end else begin
                    w_phase_n = r_phase - LEN_W'(1);
                end
            end

            default: begin
                w_state_n = IDLE;
                w_pulse_n = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign pulse      = r_pulse;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sent_count = r_sent;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: expected per-cycle outputs are
// derived from the train timing formulas and queued as stimulus is driven.
module tb_pulse_train_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pulse_num = '0;
    logic [15:0] high_len = '0;
    logic [15:0] low_len = '0;
    logic        pulse;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;

    int n_vec = 0;
    int n_err = 0;
    int last_sent = 0;

    typedef struct {
        logic p;
        logic b;
        logic d;
        int   s;
    } exp_t;

    exp_t exp_q[$];

    pulse_train_gen #(.CNT_W(16), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pulse_num  (pulse_num),
        .high_len   (high_len),
        .low_len    (low_len),
        .pulse      (pulse),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    // Reference receiver: two-flop rising-edge counter fed by pulse.
    logic rx_s1, rx_s2;
    int   rx_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1  <= 1'b0;
            rx_s2  <= 1'b0;
            rx_cnt <= 0;
        end else begin
            rx_s1 <= pulse;
            rx_s2 <= rx_s1;
            if (rx_s1 && !rx_s2) rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d want %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic push(input logic p, input logic b, input logic d, input int s);
        exp_t e;
        e.p = p; e.b = b; e.d = d; e.s = s;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare the oldest expectation 1 ns after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pulse", 32'(pulse), 32'(e.p));
            chk("busy",  32'(busy),  32'(e.b));
            chk("done",  32'(done),  32'(e.d));
            chk("sent",  32'(sent_count), 32'(e.s));
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            push(1'b0, 1'b0, 1'b0, last_sent);
            tick();
        end
    endtask

    function automatic logic exp_pulse(input int c, input int total, input int he, input int p);
        return (c <= total) && (((c - 1) % p) < he);
    endfunction

    function automatic int exp_sent(input int c, input int total, input int n, input int he, input int p);
        int k, r;
        if (c > total) return n;
        k = (c - 1) / p;
        r = (c - 1) % p;
        return k + ((r >= he) ? 1 : 0);
    endfunction

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_sent",  32'(sent_count), 32'd0);
        #2;
        rst = 1'b0;
        last_sent = 0;
    endtask

    // Launch a train; optional abort / stray start / reset at a given cycle number.
    task automatic train(input int n, input int h, input int l,
                         input int abort_c, input int start_c, input int rst_c);
        int he, le, p, total, s;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        p = he + le;
        total = n * p;
        pulse_num = 16'(n);
        high_len  = 16'(h);
        low_len   = 16'(l);
        start = 1'b1;
        for (int c = 1; c <= total + 1; c++) begin
            push(exp_pulse(c, total, he, p), c <= total, c == total + 1,
                 exp_sent(c, total, n, he, p));
            tick();
            start = 1'b0;
            pulse_num = 16'($urandom_range(0, 9));
            high_len  = 16'($urandom_range(0, 7));
            low_len   = 16'($urandom_range(0, 7));
            if (c == start_c) start = 1'b1;
            if (c == rst_c) begin
                do_reset();
                return;
            end
            if (c == abort_c) begin
                s = exp_sent(c, total, n, he, p);
                abort = 1'b1;
                push(1'b0, 1'b0, 1'b0, s);
                tick();
                abort = 1'b0;
                last_sent = s;
                return;
            end
        end
        last_sent = n;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulse", 32'(pulse), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_sent",  32'(sent_count), 32'd0);
        rst = 1'b0;
        idle(2);

        // basic train 11000 x3
        train(3, 2, 3, 0, 0, 0);
        idle(2);
        // zero pulses: immediate done, no busy
        train(0, 5, 5, 0, 0, 0);
        idle(2);
        // zero lengths clamp to one
        train(2, 0, 0, 0, 0, 0);
        idle(1);
        // abort in 2nd cycle of 3rd high phase
        train(5, 4, 4, 18, 0, 0);
        idle(2);
        // abort in IDLE suppresses start
        pulse_num = 16'd3; high_len = 16'd1; low_len = 16'd1;
        start = 1'b1; abort = 1'b1;
        push(1'b0, 1'b0, 1'b0, last_sent);
        tick();
        start = 1'b0; abort = 1'b0;
        idle(2);
        // start during a train is ignored
        train(2, 3, 2, 0, 4, 0);
        idle(1);
        // back-to-back: start in the done cycle
        train(1, 1, 1, 0, 0, 0);
        train(1, 1, 1, 0, 0, 0);
        idle(2);
        // asynchronous reset mid-LOW, then a normal train
        train(3, 2, 3, 0, 0, 4);
        idle(1);
        train(2, 1, 2, 0, 0, 0);
        idle(3);
        // loopback into edge counter
        base = rx_cnt;
        train(100, 1, 1, 0, 0, 0);
        idle(2);
        chk("loopback_edges", 32'(rx_cnt - base), 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
